// File: rtl/phy_hard_reset_tx_pkg.sv
// Shared definitions for the PD PHY Hard Reset transmitter: FSM states, K-codes and
// frame geometry, plus the bit-index to NRZ-bit mapping of the Hard Reset frame.
package phy_hard_reset_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_IDLE = 3'd1,
        ST_PREAMBLE  = 3'd2,
        ST_ORDSET    = 3'd3,
        ST_DONE      = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

    localparam logic [4:0] K_RST1 = 5'b00111;
    localparam logic [4:0] K_RST2 = 5'b11001;

    localparam int PREAMBLE_BITS = 64;
    localparam int ORDSET_BITS   = 20;
    localparam int FRAME_BITS    = PREAMBLE_BITS + ORDSET_BITS;
    localparam int K_BITS        = 5;
    localparam int RST1_REPEATS  = 3;

    // Preamble alternates starting with 0; ordered set is RST-1 x3 then RST-2, each LSB first.
    function automatic logic frame_bit(input logic [6:0] idx);
        logic [6:0] os_idx;
        logic [4:0] code;
        logic [2:0] pos;
        if (idx < 7'(PREAMBLE_BITS)) begin
            return idx[0];
        end
        os_idx = idx - 7'(PREAMBLE_BITS);
        code   = (os_idx < 7'(RST1_REPEATS * K_BITS)) ? K_RST1 : K_RST2;
        pos    = 3'(os_idx % 7'(K_BITS));
        return code[pos];
    endfunction

endpackage

// File: rtl/phy_hard_reset_tx_if.sv
// TCPC/receiver-facing signal bundle of the Hard Reset transmitter.
// master = TCPC/receiver side, slave = the transmitter.
interface phy_hard_reset_tx_if;

    logic PHY_HARD_RESET_REQ;
    logic PHY_Stop_Attempting_Reset;
    logic CC_BUSY;
    logic TX_DATA;
    logic TX_EN;
    logic PHY_ACK;
    logic PHY_FAIL;
    logic BUSY;

    modport master (
        output PHY_HARD_RESET_REQ,
        output PHY_Stop_Attempting_Reset,
        output CC_BUSY,
        input  TX_DATA,
        input  TX_EN,
        input  PHY_ACK,
        input  PHY_FAIL,
        input  BUSY
    );

    modport slave (
        input  PHY_HARD_RESET_REQ,
        input  PHY_Stop_Attempting_Reset,
        input  CC_BUSY,
        output TX_DATA,
        output TX_EN,
        output PHY_ACK,
        output PHY_FAIL,
        output BUSY
    );

endinterface

// File: rtl/phy_hard_reset_tx_bit_timer.sv
// Bit timer: divides CLK by BIT_DIV and counts frame bits 0..FRAME_BITS-1 while run is high.
// Both counters clear whenever run is low so every frame starts from bit 0, cycle 0.
module phy_hard_reset_tx_bit_timer
    import phy_hard_reset_tx_pkg::*;
#(
    parameter int BIT_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       bit_tick,
    output logic [6:0] bit_idx
);

    localparam int              DIV_W    = $clog2(BIT_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [6:0]       LAST_IDX = 7'(FRAME_BITS - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [6:0]       bit_q, bit_d;

    assign bit_tick = run && (div_q == DIV_LAST);
    assign bit_idx  = bit_q;

    always_comb begin
        div_d = '0;
        bit_d = '0;
        if (run) begin
            if (bit_tick) begin
                bit_d = (bit_q == LAST_IDX) ? 7'd0 : bit_q + 7'd1;
            end else begin
                div_d = div_q + 1'b1;
                bit_d = bit_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            bit_q <= '0;
        end else begin
            div_q <= div_d;
            bit_q <= bit_d;
        end
    end

endmodule

// File: rtl/phy_hard_reset_tx.sv
// PHY-side Hard Reset transmitter: on a request edge waits for an idle CC line, then sends
// the 64-bit preamble and RST-1 x3 / RST-2 as NRZ bits, reporting PHY_ACK or PHY_FAIL.
module phy_hard_reset_tx
    import phy_hard_reset_tx_pkg::*;
#(
    parameter int BIT_DIV      = 4,
    parameter int IDLE_TIMEOUT = 64
) (
    input logic                 CLK,
    input logic                 reset,
    phy_hard_reset_tx_if.slave  bus
);

    localparam int              TO_W     = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(IDLE_TIMEOUT - 1);
    localparam logic [6:0]      PRE_LAST = 7'(PREAMBLE_BITS - 1);
    localparam logic [6:0]      FRM_LAST = 7'(FRAME_BITS - 1);

    state_e          state_q, state_d;
    logic            req_q, req_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            start;
    logic            stop;
    logic            tx_active;
    logic            bit_tick;
    logic [6:0]      bit_idx;

    assign stop      = bus.PHY_Stop_Attempting_Reset;
    assign start     = bus.PHY_HARD_RESET_REQ & ~req_q;
    assign tx_active = (state_q == ST_PREAMBLE) || (state_q == ST_ORDSET);

    phy_hard_reset_tx_bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_bit_timer (
        .clk      (CLK),
        .rst_n    (reset),
        .run      (tx_active),
        .bit_tick (bit_tick),
        .bit_idx  (bit_idx)
    );

    // Stop has priority in every non-idle state, including the transition into DONE/FAIL.
    always_comb begin
        state_d = state_q;
        to_d    = '0;
        req_d   = bus.PHY_HARD_RESET_REQ;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop) state_d = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (stop)                 state_d = ST_IDLE;
                else if (!bus.CC_BUSY)    state_d = ST_PREAMBLE;
                else if (to_q == TO_LAST) state_d = ST_FAIL;
                else                      to_d    = to_q + 1'b1;
            end
            ST_PREAMBLE: begin
                if (stop)                                state_d = ST_IDLE;
                else if (bit_tick && bit_idx == PRE_LAST) state_d = ST_ORDSET;
            end
            ST_ORDSET: begin
                if (stop)                                state_d = ST_IDLE;
                else if (bit_tick && bit_idx == FRM_LAST) state_d = ST_DONE;
            end
            ST_DONE, ST_FAIL: state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            to_q    <= to_d;
        end
    end

    // Outputs decode straight from the state register so reset clears them without a clock.
    assign bus.TX_EN    = tx_active;
    assign bus.TX_DATA  = tx_active & frame_bit(bit_idx);
    assign bus.PHY_ACK  = (state_q == ST_DONE) & ~stop;
    assign bus.PHY_FAIL = (state_q == ST_FAIL) & ~stop;
    assign bus.BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_phy_hard_reset_tx.sv
// Scoreboard bench for phy_hard_reset_tx: stimulus pushes expected frames/pulses, a negedge
// monitor reassembles what the DUT emits and pops/compares.
module tb_phy_hard_reset_tx;

    localparam int BIT_DIV      = 4;
    localparam int IDLE_TIMEOUT = 64;
    localparam int NBITS        = 84;
    localparam int FRAME_LEN    = NBITS * BIT_DIV;
    localparam int EV_FRAME     = 0;
    localparam int EV_ACK       = 1;
    localparam int EV_FAIL      = 2;

    typedef struct {
        int kind;
        int lat;
        int len;
    } exp_t;

    logic CLK;
    logic reset;

    phy_hard_reset_tx_if bus();

    phy_hard_reset_tx #(
        .BIT_DIV      (BIT_DIV),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          cyc          = 0;
    int          req_cyc      = 0;
    logic [83:0] model_frame;
    logic [19:0] ordset_tx;

    logic        en_prev       = 1'b0;
    int          run_len       = 0;
    int          run_start     = 0;
    logic [83:0] run_bits      = '0;
    logic        run_stable    = 1'b1;
    logic        cur_bit       = 1'b0;
    logic        idle_data_bad = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic string kindName(input int k);
        case (k)
            EV_FRAME: return "frame";
            EV_ACK:   return "ack";
            EV_FAIL:  return "fail";
            default:  return "unknown";
        endcase
    endfunction

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic stop, input logic cc_busy);
        bus.PHY_HARD_RESET_REQ        = req;
        bus.PHY_Stop_Attempting_Reset = stop;
        bus.CC_BUSY                   = cc_busy;
    endtask

    task automatic pushExpected(input int kind, input int lat, input int len);
        exp_t e;
        e.kind = kind;
        e.lat  = lat;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int actual, input int required);
        n_compared++;
        if (actual != required) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic scoreEvent(input int kind, input int lat, input int len,
                              input logic [83:0] bits, input logic ok);
        exp_t        e;
        logic [83:0] mask;
        int          nb;
        n_compared++;
        if (exp_q.size() == 0) begin
            n_mismatched++;
            $display("[TB] FAIL unexpected_%s: got lat=%0d len=%0d, required no event",
                     kindName(kind), lat, len);
            return;
        end
        e    = exp_q.pop_front();
        mask = '0;
        nb   = (len + BIT_DIV - 1) / BIT_DIV;
        for (int i = 0; i < nb && i < NBITS; i++) mask[i] = 1'b1;
        if (kind != e.kind || lat != e.lat || len != e.len || ok !== 1'b1 ||
            ((bits ^ model_frame) & mask) != '0) begin
            n_mismatched++;
            $display("[TB] FAIL scoreboard_%s: got %s lat=%0d len=%0d ok=%0b bits=%h, required %s lat=%0d len=%0d ok=1 bits=%h",
                     kindName(e.kind), kindName(kind), lat, len, ok, bits & mask,
                     kindName(e.kind), e.lat, e.len, model_frame & mask);
        end
    endtask

    // Monitor: rebuilds each TX_EN burst one sample per bit period and checks mid-bit stability.
    always @(negedge CLK) begin
        if (bus.TX_EN === 1'b1) begin
            if (!en_prev) begin
                run_len    = 0;
                run_bits   = '0;
                run_stable = 1'b1;
                run_start  = cyc;
            end
            if (run_len % BIT_DIV == 0) begin
                cur_bit = bus.TX_DATA;
                if (run_len / BIT_DIV < NBITS) run_bits[run_len / BIT_DIV] = bus.TX_DATA;
            end else if (bus.TX_DATA !== cur_bit) begin
                run_stable = 1'b0;
            end
            run_len++;
        end else begin
            if (bus.TX_DATA !== 1'b0) idle_data_bad = 1'b1;
            if (en_prev) scoreEvent(EV_FRAME, run_start - req_cyc, run_len, run_bits, run_stable);
        end
        if (bus.PHY_ACK === 1'b1)
            scoreEvent(EV_ACK, cyc - req_cyc, 0, '0, en_prev && (bus.TX_EN === 1'b0));
        if (bus.PHY_FAIL === 1'b1)
            scoreEvent(EV_FAIL, cyc - req_cyc, 0, '0, !en_prev && (bus.TX_EN === 1'b0));
        en_prev = (bus.TX_EN === 1'b1);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish by time %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ordset_tx = 20'b11001_00111_00111_00111;
        for (int i = 0; i < 64; i++) model_frame[i] = (i % 2 == 1);
        for (int i = 0; i < 20; i++) model_frame[64 + i] = ordset_tx[i];

        applyStimulus(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) nextCycle();
        checkOutput("reset_outputs",
                    int'({bus.TX_EN, bus.TX_DATA, bus.PHY_ACK, bus.PHY_FAIL, bus.BUSY}), 0);
        reset = 1'b1;
        repeat (3) nextCycle();

        $display("[TB] basic send");
        applyStimulus(1'b1, 1'b0, 1'b0);
        req_cyc = cyc;
        pushExpected(EV_FRAME, 2, FRAME_LEN);
        pushExpected(EV_ACK, 2 + FRAME_LEN, 0);
        repeat (345) nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (10) nextCycle();

        $display("[TB] busy line for 10 cycles");
        applyStimulus(1'b1, 1'b0, 1'b1);
        req_cyc = cyc;
        pushExpected(EV_FRAME, 11, FRAME_LEN);
        pushExpected(EV_ACK, 11 + FRAME_LEN, 0);
        repeat (10) nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (350) nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (10) nextCycle();

        $display("[TB] idle timeout");
        applyStimulus(1'b1, 1'b0, 1'b1);
        req_cyc = cyc;
        pushExpected(EV_FAIL, IDLE_TIMEOUT + 1, 0);
        repeat (70) nextCycle();
        checkOutput("fail_busy_low", int'(bus.BUSY), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (10) nextCycle();

        $display("[TB] abort at preamble bit 30");
        applyStimulus(1'b1, 1'b0, 1'b0);
        req_cyc = cyc;
        pushExpected(EV_FRAME, 2, 30 * BIT_DIV + 1);
        repeat (122) nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0);
        nextCycle();
        checkOutput("abort_next_cycle", int'({bus.BUSY, bus.TX_EN, bus.TX_DATA}), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (10) nextCycle();
        checkOutput("abort_no_restart", int'(bus.BUSY), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (10) nextCycle();

        $display("[TB] request held high");
        applyStimulus(1'b1, 1'b0, 1'b0);
        req_cyc = cyc;
        pushExpected(EV_FRAME, 2, FRAME_LEN);
        pushExpected(EV_ACK, 2 + FRAME_LEN, 0);
        repeat (1000) nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (10) nextCycle();

        $display("[TB] second request edge mid-frame");
        applyStimulus(1'b1, 1'b0, 1'b0);
        req_cyc = cyc;
        pushExpected(EV_FRAME, 2, FRAME_LEN);
        pushExpected(EV_ACK, 2 + FRAME_LEN, 0);
        repeat (50) nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (50) nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (300) nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (20) nextCycle();

        $display("[TB] stop held in idle");
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (3) nextCycle();
        checkOutput("stop_idle_blocks", int'(bus.BUSY), 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (5) nextCycle();
        checkOutput("stop_idle_no_retrigger", int'(bus.BUSY), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (5) nextCycle();

        $display("[TB] async reset mid ordered set");
        applyStimulus(1'b1, 1'b0, 1'b0);
        req_cyc = cyc;
        pushExpected(EV_FRAME, 2, 298);
        repeat (299) nextCycle();
        @(posedge CLK);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    int'({bus.TX_EN, bus.TX_DATA, bus.PHY_ACK, bus.PHY_FAIL, bus.BUSY}), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) nextCycle();
        reset = 1'b1;
        repeat (3) nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0);
        req_cyc = cyc;
        pushExpected(EV_FRAME, 2, FRAME_LEN);
        pushExpected(EV_ACK, 2 + FRAME_LEN, 0);
        repeat (345) nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (10) nextCycle();

        $display("[TB] stop on last bit tick");
        applyStimulus(1'b1, 1'b0, 1'b0);
        req_cyc = cyc;
        pushExpected(EV_FRAME, 2, FRAME_LEN);
        repeat (1 + FRAME_LEN) nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0);
        nextCycle();
        checkOutput("stop_last_tick_idle", int'({bus.BUSY, bus.TX_EN, bus.PHY_ACK}), 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (10) nextCycle();

        checkOutput("scoreboard_drained", exp_q.size(), 0);
        checkOutput("tx_data_zero_when_idle", int'(idle_data_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
